// File: rtl/lcd_writer_pkg.sv
// lcd_writer_pkg: FSM states, init step list and long-command rules for lcd_writer.
package lcd_writer_pkg;

   typedef enum logic [2:0] {PWR_WAIT, LOAD, SETUP, PULSE, HOLD, GAP, EXEC, IDLE} state_t;
   typedef enum logic [1:0] {WS_INIT1, WS_INIT2, WS_CMD, WS_LONG} wsel_t;

   typedef struct packed {
      logic       nib_only;
      logic [7:0] data;
      wsel_t      wsel;
   } step_t;

   localparam int         N_INIT       = 8;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   // Nibble-only steps carry their nibble in the high half of data.
   function automatic step_t init_step(input logic [3:0] i);
      case (i)
         4'd0:    return '{1'b1, 8'h30, WS_INIT1};
         4'd1:    return '{1'b1, 8'h30, WS_INIT2};
         4'd2:    return '{1'b1, 8'h30, WS_CMD};
         4'd3:    return '{1'b1, 8'h20, WS_CMD};
         4'd4:    return '{1'b0, 8'h28, WS_CMD};
         4'd5:    return '{1'b0, 8'h06, WS_CMD};
         4'd6:    return '{1'b0, 8'h0C, WS_CMD};
         4'd7:    return '{1'b0, CMD_CLEAR, WS_LONG};
         default: return '{1'b0, 8'h00, WS_CMD};
      endcase
   endfunction

   function automatic logic is_long(input logic rs_bit, input logic [7:0] d);
      return !rs_bit && (d == CMD_CLEAR || d == CMD_HOME || d == CMD_HOME_ALT);
   endfunction

   function automatic int imax(input int a, input int b);
      return a > b ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that stops at zero and flags done there.
module lcd_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_cnt <= RST_VAL;
      else if (i_load)         r_cnt <= i_val;
      else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = r_cnt == '0;

endmodule

// File: rtl/lcd_writer.sv
// lcd_writer: write-only HD44780 4-bit controller with autonomous init and a
// valid/ready byte port; all delays come from one shared timer.
module lcd_writer
   import lcd_writer_pkg::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_INIT1   = 205000,
   parameter int T_INIT2   = 5000,
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 12,
   parameter int T_HOLD    = 2,
   parameter int T_NIBBLE  = 50,
   parameter int T_CMD     = 2000,
   parameter int T_LONG    = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid,
   input  logic       rs_in,
   input  logic [7:0] data_in,
   output logic       ready,
   output logic       init_done,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic [3:0] lcd_d
);

   localparam int W = $clog2(imax(imax(imax(T_POWERUP, T_INIT1), imax(T_INIT2, T_SETUP)),
                                  imax(imax(T_PULSE, T_HOLD), imax(imax(T_NIBBLE, T_CMD), T_LONG))) + 1);

   localparam logic [W-1:0] L_SETUP  = W'(T_SETUP - 1);
   localparam logic [W-1:0] L_PULSE  = W'(T_PULSE - 1);
   localparam logic [W-1:0] L_HOLD   = W'(T_HOLD - 1);
   localparam logic [W-1:0] L_NIBBLE = W'(T_NIBBLE - 1);
   localparam logic [W-1:0] L_INIT1  = W'(T_INIT1 - 1);
   localparam logic [W-1:0] L_INIT2  = W'(T_INIT2 - 1);
   localparam logic [W-1:0] L_CMD    = W'(T_CMD - 1);
   localparam logic [W-1:0] L_LONG   = W'(T_LONG - 1);

   state_t       r_state, w_next;
   wsel_t        r_wsel;
   step_t        w_step;
   logic [3:0]   r_step;
   logic [7:0]   r_data;
   logic         r_rs, r_nib_only, r_lo;
   logic         w_done, w_lo, w_drive, w_init_end;
   logic [W-1:0] w_tval, w_post;

   // The timer reloads on every state change, so each timed state lasts N cycles.
   lcd_timer #(.W(W), .RST_VAL(W'(T_POWERUP - 1))) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_next != r_state),
      .i_val  (w_tval),
      .o_done (w_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= PWR_WAIT;
      else        r_state <= w_next;
   end

   assign w_init_end = r_step == 4'(N_INIT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         PWR_WAIT: w_next = w_done ? LOAD : PWR_WAIT;
         LOAD:     w_next = SETUP;
         SETUP:    w_next = w_done ? PULSE : SETUP;
         PULSE:    w_next = w_done ? HOLD : PULSE;
         HOLD:     w_next = !w_done ? HOLD : (r_lo || r_nib_only) ? EXEC : GAP;
         GAP:      w_next = w_done ? SETUP : GAP;
         EXEC:     w_next = !w_done ? EXEC : (init_done || w_init_end) ? IDLE : LOAD;
         IDLE:     w_next = valid ? LOAD : IDLE;
      endcase
   end

   assign w_step  = init_step(r_step);
   assign w_lo    = r_lo || r_state == GAP;
   assign w_drive = w_next inside {SETUP, PULSE, HOLD};
   assign w_post  = r_wsel == WS_INIT1 ? L_INIT1 :
                    r_wsel == WS_INIT2 ? L_INIT2 :
                    r_wsel == WS_LONG  ? L_LONG  : L_CMD;
   assign w_tval  = w_next == SETUP ? L_SETUP  :
                    w_next == PULSE ? L_PULSE  :
                    w_next == HOLD  ? L_HOLD   :
                    w_next == GAP   ? L_NIBBLE :
                    w_next == EXEC  ? w_post   : '0;
   assign rw      = 1'b0;

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e          <= 1'b0;
         rs         <= 1'b0;
         lcd_d      <= 4'h0;
         ready      <= 1'b0;
         init_done  <= 1'b0;
         r_step     <= 4'd0;
         r_data     <= 8'h00;
         r_rs       <= 1'b0;
         r_nib_only <= 1'b0;
         r_wsel     <= WS_CMD;
         r_lo       <= 1'b0;
      end else begin
         e          <= w_next == PULSE;
         rs         <= w_drive && r_rs;
         lcd_d      <= w_drive ? (w_lo ? r_data[3:0] : r_data[7:4]) : 4'h0;
         ready      <= w_next == IDLE;
         init_done  <= init_done || (r_state == EXEC && w_next == IDLE);
         r_lo       <= w_next == LOAD ? 1'b0 : w_lo;
         if (w_next == LOAD && r_state == IDLE) begin
            r_data     <= data_in;
            r_rs       <= rs_in;
            r_nib_only <= 1'b0;
            r_wsel     <= is_long(rs_in, data_in) ? WS_LONG : WS_CMD;
         end else if (w_next == LOAD) begin
            r_data     <= w_step.data;
            r_rs       <= 1'b0;
            r_nib_only <= w_step.nib_only;
            r_wsel     <= w_step.wsel;
            r_step     <= r_step + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_writer.sv
// tb_lcd_writer: table-driven byte writes plus hand sequences for init,
// busy requests, back-to-back bytes and reset mid-pulse.
module tb_lcd_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       valid = 1'b0;
   logic       rs_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready, init_done, e, rs, rw;
   logic [3:0] lcd_d;

   int   total = 0, bad = 0, cyc = 0, rw_bad = 0, e_w = 0, rel = 0;
   bit   e_prev = 1'b0, chk_width = 1'b1;
   logic [3:0] nibs[$];
   logic       rss[$];
   int         rise_cyc[$];
   logic [3:0] exp_init[12];

   typedef struct {
      logic       r;
      logic [7:0] d;
      logic [3:0] hi;
      logic [3:0] lo;
      int         lat;
   } vec_t;
   vec_t vecs[8];

   lcd_writer #(
      .T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(2), .T_PULSE(3),
      .T_HOLD(2), .T_NIBBLE(4), .T_CMD(6), .T_LONG(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .rs_in(rs_in), .data_in(data_in),
      .ready(ready), .init_done(init_done), .e(e), .rs(rs), .rw(rw), .lcd_d(lcd_d)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Record nibble/rs at every E rise and check every complete pulse width.
   always @(negedge clk) begin
      if (rw !== 1'b0) rw_bad++;
      if (e === 1'b1 && !e_prev) begin
         nibs.push_back(lcd_d);
         rss.push_back(rs);
         rise_cyc.push_back(cyc);
      end
      if (e === 1'b1) e_w++;
      else begin
         if (e_prev && chk_width) chk("e_width", e_w, 3);
         e_w = 0;
      end
      e_prev = (e === 1'b1);
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("ready_timeout", ready, 1);
   endtask

   task automatic run_init();
      int n = 0;
      nibs.delete();
      rss.delete();
      rise_cyc.delete();
      rst_n = 1'b1;
      rel = cyc;
      chk_width = 1'b1;
      while (init_done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("init_nibble_count", nibs.size(), 12);
      for (int i = 0; i < 12 && i < nibs.size(); i++) begin
         chk($sformatf("init_nib%0d", i), nibs[i], exp_init[i]);
         chk($sformatf("init_rs%0d", i), rss[i], 0);
      end
      if (rise_cyc.size() > 0) chk("first_e_rise", rise_cyc[0] - rel, 23);
      chk("ready_after_init", ready, 1);
      chk("init_done_after_init", init_done, 1);
   endtask

   task automatic do_write(input logic r, input logic [7:0] d, output int lat);
      wait_ready();
      rs_in = r;
      data_in = d;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (ready !== 1'b1 && lat < 500);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, lat, n;
      exp_init = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
      vecs = '{
         '{1'b1, 8'h41, 4'h4, 4'h1, 25},
         '{1'b0, 8'h01, 4'h0, 4'h1, 34},
         '{1'b0, 8'h02, 4'h0, 4'h2, 34},
         '{1'b0, 8'h03, 4'h0, 4'h3, 34},
         '{1'b0, 8'h04, 4'h0, 4'h4, 25},
         '{1'b1, 8'h01, 4'h0, 4'h1, 25},
         '{1'b0, 8'h80, 4'h8, 4'h0, 25},
         '{1'b0, 8'h00, 4'h0, 4'h0, 25}
      };
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_e", e, 0);
      chk("rst_rs", rs, 0);
      chk("rst_rw", rw, 0);
      chk("rst_lcd_d", lcd_d, 0);
      chk("rst_ready", ready, 0);
      chk("rst_init_done", init_done, 0);
      run_init();

      foreach (vecs[i]) begin
         base = nibs.size();
         do_write(vecs[i].r, vecs[i].d, lat);
         chk($sformatf("v%0d_pulses", i), nibs.size() - base, 2);
         chk($sformatf("v%0d_hi", i), nibs[base], vecs[i].hi);
         chk($sformatf("v%0d_lo", i), nibs[base + 1], vecs[i].lo);
         chk($sformatf("v%0d_rs_hi", i), rss[base], vecs[i].r);
         chk($sformatf("v%0d_rs_lo", i), rss[base + 1], vecs[i].r);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      end

      // Busy request is dropped; a held request is taken on the first ready cycle.
      base = nibs.size();
      wait_ready();
      rs_in = 1'b1;
      data_in = 8'h41;
      valid = 1'b1;
      @(posedge clk);
      #1 rs_in = 1'b0;
      data_in = 8'h55;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rs_in = 1'b1;
      data_in = 8'h42;
      valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 valid = 1'b0;
      chk("busy_ready_drop", ready, 0);
      wait_ready();
      chk("busy_pulses", nibs.size() - base, 4);
      chk("busy_n0", nibs[base], 4'h4);
      chk("busy_n1", nibs[base + 1], 4'h1);
      chk("busy_n2", nibs[base + 2], 4'h4);
      chk("busy_n3", nibs[base + 3], 4'h2);
      chk("busy_gap", rise_cyc[base + 2] - rise_cyc[base + 1], 15);

      // Back-to-back bytes with valid held.
      base = nibs.size();
      wait_ready();
      rs_in = 1'b1;
      data_in = 8'h48;
      valid = 1'b1;
      @(posedge clk);
      #1 data_in = 8'h49;
      wait_ready();
      @(posedge clk);
      #1 valid = 1'b0;
      wait_ready();
      chk("b2b_pulses", nibs.size() - base, 4);
      chk("b2b_n0", nibs[base], 4'h4);
      chk("b2b_n1", nibs[base + 1], 4'h8);
      chk("b2b_n2", nibs[base + 2], 4'h4);
      chk("b2b_n3", nibs[base + 3], 4'h9);
      chk("b2b_gap_min", (rise_cyc[base + 2] - rise_cyc[base + 1]) >= 7, 1);
      chk("b2b_gap", rise_cyc[base + 2] - rise_cyc[base + 1], 15);

      // Reset while E is high.
      wait_ready();
      rs_in = 1'b1;
      data_in = 8'h41;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (e !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_e_high", e, 1);
      #2 chk_width = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_e", e, 0);
      chk("mid_rst_lcd_d", lcd_d, 0);
      chk("mid_rst_rs", rs, 0);
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_init_done", init_done, 0);
      repeat (2) @(negedge clk);
      run_init();

      chk("rw_never_high", rw_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
